// File: rtl/approx_mult_scheduler.sv
// Round-robin scheduler sharing one combinational approximate multiplier between
// requesters A and B; one transaction in flight, result returned on valid/ready.
module approx_mult_scheduler #(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               a_valid,
   output logic               a_ready,
   input  logic [WIDTH-1:0]   a_in1,
   input  logic [WIDTH-1:0]   a_in2,
   input  logic               a_mask,
   input  logic               b_valid,
   output logic               b_ready,
   input  logic [WIDTH-1:0]   b_in1,
   input  logic [WIDTH-1:0]   b_in2,
   input  logic               b_mask,
   output logic [WIDTH-1:0]   mul_in1,
   output logic [WIDTH-1:0]   mul_in2,
   output logic               mul_mask,
   input  logic [2*WIDTH-1:0] mul_out,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [2*WIDTH-1:0] resp_data,
   output logic               resp_id,
   output logic               busy
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic            last_grant;   // 1 = B was served last
   logic            grant_a, grant_b, hs;

   always_comb begin
      grant_a = a_valid && (!b_valid || last_grant);
      grant_b = b_valid && (!a_valid || !last_grant);
   end

   // Readies are gated by rst so a handshake can never coincide with reset.
   assign a_ready = (state == IDLE) && grant_a && !rst;
   assign b_ready = (state == IDLE) && grant_b && !rst;
   assign hs      = (a_valid && a_ready) || (b_valid && b_ready);
   assign busy    = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (hs) state_nxt = CALC;
         CALC:    if (cnt == '0) state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mul_in1    <= '0;
         mul_in2    <= '0;
         mul_mask   <= 1'b0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_id    <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= '0;
      end else begin
         case (state)
            IDLE: if (hs) begin
               mul_in1    <= grant_b ? b_in1  : a_in1;
               mul_in2    <= grant_b ? b_in2  : a_in2;
               mul_mask   <= grant_b ? b_mask : a_mask;
               resp_id    <= grant_b;
               last_grant <= grant_b;
               cnt        <= CW'(SETTLE - 1);
            end
            CALC: begin
               if (cnt == '0) begin
                  resp_data  <= mul_out;
                  resp_valid <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: if (resp_ready) resp_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_approx_mult_scheduler.sv
// Bench for approx_mult_scheduler: two instances (SETTLE=1, SETTLE=3), each with a
// transaction-level reference model, directed literal cases and random traffic.
module tb_approx_mult_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input int s, input string nm, input longint got, input longint exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL settle%0d %s: got %0d expected %0d", s, nm, got, exp);
      end
   endtask

   function automatic logic [7:0] rnd8();
      if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      return 8'($urandom_range(0, 255));
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g
      localparam int S = (gi == 0) ? 1 : 3;

      logic       rst, a_valid, a_ready, a_mask, b_valid, b_ready, b_mask;
      logic       mul_mask, resp_valid, resp_ready, resp_id, busy;
      logic [7:0] a_in1, a_in2, b_in1, b_in2, mul_in1, mul_in2;
      logic [15:0] mul_out, resp_data;
      bit         fin = 1'b0;

      // exact multiplier stub
      assign mul_out = 16'(mul_in1) * 16'(mul_in2);

      approx_mult_scheduler #(.WIDTH(8), .SETTLE(S)) dut (
         .clk(clk), .rst(rst),
         .a_valid(a_valid), .a_ready(a_ready), .a_in1(a_in1), .a_in2(a_in2), .a_mask(a_mask),
         .b_valid(b_valid), .b_ready(b_ready), .b_in1(b_in1), .b_in2(b_in2), .b_mask(b_mask),
         .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_mask(mul_mask), .mul_out(mul_out),
         .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
         .resp_id(resp_id), .busy(busy)
      );

      // Model: a transaction accepted in cycle t is busy from t+1, responds from t+1+S
      // until accepted; results and latched operands are tracked as plain values.
      bit          m_on = 0, m_busy = 0, m_last = 1, e_mask = 0, e_id = 0;
      int          m_hs = 0, cyc = 0;
      logic [7:0]  e_in1 = 0, e_in2 = 0;
      logic [15:0] e_prod = 0, e_hold = 0;

      initial begin
         bit ga, gb, rv;
         forever begin
            @(negedge clk);
            ga = m_on && !rst && !m_busy && a_valid && (!b_valid || m_last);
            gb = m_on && !rst && !m_busy && b_valid && (!a_valid || !m_last);
            rv = m_busy && (cyc >= m_hs + 1 + S);
            if (m_on) begin
               chk(S, "a_ready",    a_ready,    ga);
               chk(S, "b_ready",    b_ready,    gb);
               chk(S, "busy",       busy,       m_busy);
               chk(S, "resp_valid", resp_valid, rv);
               chk(S, "mul_in1",    mul_in1,    e_in1);
               chk(S, "mul_in2",    mul_in2,    e_in2);
               chk(S, "mul_mask",   mul_mask,   e_mask);
               chk(S, "resp_id",    resp_id,    e_id);
               chk(S, "resp_data",  resp_data,  rv ? e_prod : e_hold);
            end
            if (rst) begin
               m_on = 1; m_busy = 0; m_last = 1;
               e_in1 = 0; e_in2 = 0; e_mask = 0; e_id = 0; e_hold = 0; e_prod = 0;
            end else if (ga || gb) begin
               m_busy = 1; m_hs = cyc; m_last = gb; e_id = gb;
               e_in1  = gb ? b_in1 : a_in1;
               e_in2  = gb ? b_in2 : a_in2;
               e_mask = gb ? b_mask : a_mask;
               e_prod = 16'(e_in1) * 16'(e_in2);
            end else if (rv && resp_ready) begin
               m_busy = 0; e_hold = e_prod;
            end
            cyc++;
         end
      end

      task automatic issue(input bit who, input logic [7:0] x, input logic [7:0] y, input bit m,
                           output logic [15:0] d, output bit id, output int lat, output bit mk);
         bit got;
         @(posedge clk); #1;
         resp_ready = 1;
         if (!who) begin a_valid = 1; a_in1 = x; a_in2 = y; a_mask = m; end
         else      begin b_valid = 1; b_in1 = x; b_in2 = y; b_mask = m; end
         got = 0;
         for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = who ? b_ready : a_ready;
         end
         chk(S, "grant_seen", got, 1);
         @(posedge clk); #1;
         a_valid = 0; b_valid = 0;
         mk  = mul_mask;
         lat = 1; got = 0;
         for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (resp_valid) got = 1; else lat++;
         end
         chk(S, "resp_seen", got, 1);
         d = resp_data; id = resp_id;
      endtask

      initial begin
         logic [15:0] d;
         bit id, mk, got, hsa, hsb;
         int lat, ng, nr, cnt_rv;
         int gt[4], gw[4], rd[4], ri[4];
         int eg[4] = '{0, 1, 0, 1};
         int ed[4] = '{15, 63, 15, 63};

         rst = 1; a_valid = 0; b_valid = 0; resp_ready = 1;
         a_in1 = 0; a_in2 = 0; a_mask = 0; b_in1 = 0; b_in2 = 0; b_mask = 0;
         repeat (2) @(posedge clk);
         #1 rst = 0;
         @(negedge clk);
         chk(S, "rst busy", busy, 0);
         chk(S, "rst resp_valid", resp_valid, 0);
         chk(S, "rst mul_in1", mul_in1, 0);
         chk(S, "rst resp_data", resp_data, 0);

         issue(0, 8'd45, 8'd44, 1'b1, d, id, lat, mk);
         chk(S, "a45x44 data", d, 16'h07BC);
         chk(S, "a45x44 id", id, 0);
         chk(S, "a45x44 mask", mk, 1);
         chk(S, "a45x44 latency", lat, S + 1);

         issue(0, 8'd12, 8'd12, 1'b0, d, id, lat, mk);
         chk(S, "a12x12 data", d, 144);
         chk(S, "a12x12 latency", lat, S + 1);

         issue(1, 8'd255, 8'd255, 1'b0, d, id, lat, mk);
         chk(S, "b255x255 data", d, 16'hFE01);
         chk(S, "b255x255 id", id, 1);
         issue(0, 8'd0, 8'd200, 1'b1, d, id, lat, mk);
         chk(S, "a0x200 data", d, 0);
         chk(S, "a0x200 id", id, 0);

         // response stall with both requesters waiting
         @(posedge clk); #1;
         resp_ready = 0; a_valid = 1; a_in1 = 9; a_in2 = 9;
         got = 0;
         for (int k = 0; k < 20 && !got; k++) begin @(negedge clk); got = a_ready; end
         chk(S, "stall grant", got, 1);
         @(posedge clk); #1 b_valid = 1; b_in1 = 2; b_in2 = 2;
         got = 0;
         for (int k = 0; k < 20 && !got; k++) begin @(negedge clk); got = resp_valid; end
         chk(S, "stall resp", got, 1);
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk(S, "stall valid", resp_valid, 1);
            chk(S, "stall data", resp_data, 81);
            chk(S, "stall id", resp_id, 0);
            chk(S, "stall a_ready", a_ready, 0);
            chk(S, "stall b_ready", b_ready, 0);
            chk(S, "stall busy", busy, 1);
         end
         @(posedge clk); #1 a_valid = 0; b_valid = 0; resp_ready = 1;
         repeat (2) @(posedge clk);

         // reset while the transaction is in CALC
         #1 a_valid = 1; a_in1 = 200; a_in2 = 3;
         got = 0;
         for (int k = 0; k < 20 && !got; k++) begin @(negedge clk); got = a_ready; end
         chk(S, "rstcalc grant", got, 1);
         @(posedge clk); #1 a_valid = 0; rst = 1;
         @(posedge clk); #1 rst = 0;
         cnt_rv = 0;
         for (int k = 0; k < 8; k++) begin @(negedge clk); if (resp_valid) cnt_rv++; end
         chk(S, "rstcalc no resp", cnt_rv, 0);
         chk(S, "rstcalc busy", busy, 0);
         chk(S, "rstcalc mul_in1", mul_in1, 0);

         // both valid continuously: A first, then alternation
         @(posedge clk); #1;
         a_valid = 1; a_in1 = 3; a_in2 = 5; a_mask = 0;
         b_valid = 1; b_in1 = 7; b_in2 = 9; b_mask = 1;
         ng = 0; nr = 0;
         for (int k = 0; k < 60 && nr < 4; k++) begin
            @(negedge clk);
            if (ng < 4 && (a_ready || b_ready)) begin gw[ng] = b_ready; gt[ng] = k; ng++; end
            if (resp_valid) begin rd[nr] = resp_data; ri[nr] = resp_id; nr++; end
         end
         @(posedge clk); #1 a_valid = 0; b_valid = 0;
         chk(S, "alt grants", ng, 4);
         chk(S, "alt resps", nr, 4);
         for (int i = 0; i < 4; i++) begin
            chk(S, "alt who", gw[i], eg[i]);
            chk(S, "alt data", rd[i], ed[i]);
            chk(S, "alt id", ri[i], eg[i]);
            if (i > 0) chk(S, "alt spacing", gt[i] - gt[i-1], S + 2);
         end

         // random traffic
         repeat (1500) begin
            @(negedge clk);
            hsa = a_valid && a_ready;
            hsb = b_valid && b_ready;
            @(posedge clk); #1;
            rst = ($urandom_range(0, 149) == 0);
            if (hsa || !a_valid || $urandom_range(0, 15) == 0) begin
               a_valid = ($urandom_range(0, 2) != 0);
               a_in1 = rnd8(); a_in2 = rnd8(); a_mask = 1'($urandom_range(0, 1));
            end
            if (hsb || !b_valid || $urandom_range(0, 15) == 0) begin
               b_valid = ($urandom_range(0, 2) != 0);
               b_in1 = rnd8(); b_in2 = rnd8(); b_mask = 1'($urandom_range(0, 1));
            end
            resp_ready = ($urandom_range(0, 3) != 0);
         end
         rst = 0; a_valid = 0; b_valid = 0;
         fin = 1;
      end
   end

   initial begin
      bit ok;
      ok = 0;
      for (int k = 0; k < 40000 && !ok; k++) begin
         @(posedge clk);
         ok = g[0].fin && g[1].fin;
      end
      chk(0, "bench completion", ok, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
